// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
//
// A producer pushes bytes through a ready/valid port into a FIFO_DEPTH-entry
// FIFO. The transmit FSM pops one byte at a time and shifts it out on TX
// LSB first, framed by a start bit (0) and a stop bit (1). Each bit lasts
// DIV = CLK_FREQ/BAUD clock cycles.
//
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit. The frame grows from 10*DIV to 11*DIV cycles.
// The port list is the same in both builds.
//
// Ports:
//   Clk      system clock, rising edge
//   Rst_n    asynchronous active-low reset
//   Clear    synchronous flush: empties the FIFO and aborts the current frame
//   InData   byte to send
//   InValid  InData is valid this cycle
//   InReady  FIFO can accept; transfer happens when InValid & InReady
//   TX       serial line, idle high
//   Busy     a frame is in progress or the FIFO is not empty
//   Count    bytes held in the FIFO, not counting the frame being shifted
//
// Handshake: a byte is taken on every rising edge where InValid and InReady
// are both high. InReady is derived only from registered state, so it does
// not depend on InValid in the same cycle. A producer holds InData and
// InValid until the byte is taken.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Clear,
    input  logic [7:0]    InData,
    input  logic          InValid,
    output logic          InReady,
    output logic          TX,
    output logic          Busy,
    output logic [AW:0]   Count
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW:0]    count_q, count_d;
    logic           rdy_q;
`ifdef UART_TX_PARITY_EN
    logic           par_q, par_d;
`endif
    logic [7:0]     mem_q [FIFO_DEPTH];

    logic           push;
    logic           pop;
    logic           baud_tc;

    // rdy_q keeps InReady low while reset is held and for the release edge.
    assign InReady = rdy_q && (count_q != FULL);
    assign TX      = tx_q;
    assign Busy    = (state_q != ST_IDLE) || (count_q != '0);
    assign Count   = count_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        baud_tc = (baud_q == BAUD_LAST);
        push    = InValid && InReady && !Clear;
        // Pop uses registered Count, so a push into an empty FIFO cannot
        // be popped in the same cycle.
        pop     = (state_q == ST_IDLE) && (count_q != '0) && !Clear;

        if (Clear) begin
            state_d = ST_IDLE;
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

            // tx_d is the line level for the state being entered, so TX
            // changes on the same edge as the state.
            case (state_q)
                ST_IDLE: begin
                    tx_d = 1'b1;
                    if (pop) begin
                        shift_d = mem_q[rd_q];
`ifdef UART_TX_PARITY_EN
                        par_d   = ^mem_q[rd_q];
`endif
                        baud_d  = '0;
                        bit_d   = '0;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_tc) begin
                        baud_d  = '0;
                        state_d = ST_DATA;
                        tx_d    = shift_q[0];
                    end else begin
                        baud_d = baud_q + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_tc) begin
                        baud_d = '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
                            tx_d    = par_q;
`else
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
`endif
                        end else begin
                            shift_d = {1'b0, shift_q[7:1]};
                            bit_d   = bit_q + 3'd1;
                            tx_d    = shift_q[1];
                        end
                    end else begin
                        baud_d = baud_q + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tc) begin
                        baud_d  = '0;
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        baud_d = baud_q + BW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tc) begin
                        baud_d  = '0;
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        baud_d = baud_q + BW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            rdy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            rdy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_q] <= InData;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo (DIV = 10, depth 16).
// The reference model holds the FIFO as a byte queue and works out the line
// level from the frame bit schedule: bit k of a frame lasts DIV cycles. A
// separate line decoder samples TX at mid-bit and matches the bytes it
// recovers against the queue of accepted bytes.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 16;
    localparam int AW       = $clog2(DEPTH);
`ifdef UART_TX_PARITY_EN
    localparam int NB       = 11;
`else
    localparam int NB       = 10;
`endif
    localparam int FRAME    = NB * DIV;

    // ---------------- clock / reset / DUT ----------------
    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          Clear;
    logic [7:0]    InData;
    logic          InValid;
    logic          InReady;
    logic          TX;
    logic          Busy;
    logic [AW:0]   Count;

    always #5 Clk = ~Clk;

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Clear   (Clear),
        .InData  (InData),
        .InValid (InValid),
        .InReady (InReady),
        .TX      (TX),
        .Busy    (Busy),
        .Count   (Count)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q[$];     // accepted bytes not yet seen on the line
    logic [7:0]  mq[$];        // model FIFO contents
    logic [7:0]  cur;          // byte of the frame in flight
    bit          in_frame;
    int          off;          // cycle offset inside the current frame
    bit          m_tx;
    bit          ready_en;
    bit          acc_last;
    bit          dec_active;
    int          dec_off;
    logic [7:0]  dec_byte;
    bit          prev_tx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == NB - 1) return 1'b1;
        return ^b;   // parity slot
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        in_frame   = 0;
        off        = 0;
        m_tx       = 1;
        ready_en   = 0;
        acc_last   = 0;
        dec_active = 0;
        prev_tx    = 1;
    endtask

    // Advance the model across the next rising edge using the driven inputs.
    task automatic model_edge();
        bit acc;
        acc_last = 0;
        if (!Rst_n) begin
            model_reset();
            return;
        end
        if (Clear) begin
            model_reset();
            ready_en = 1;
            return;
        end
        acc = InValid && ready_en && (mq.size() != DEPTH);
        if (in_frame) begin
            off++;
            if (off == FRAME) begin
                in_frame = 0;
                m_tx     = 1;
            end else begin
                m_tx = frame_bit(cur, off / DIV);
            end
        end else if (mq.size() != 0) begin
            cur      = mq.pop_front();
            in_frame = 1;
            off      = 0;
            m_tx     = 0;
        end else begin
            m_tx = 1;
        end
        if (acc) begin
            mq.push_back(InData);
            exp_q.push_back(InData);
        end
        acc_last = acc;
        ready_en = 1;
    endtask

    // Mid-bit line decoder, independent of the cycle-level model.
    task automatic decode();
        if (!dec_active) begin
            if (prev_tx && !TX) begin
                dec_active = 1;
                dec_off    = 0;
                dec_byte   = '0;
            end
        end else begin
            dec_off++;
            for (int i = 0; i < 8; i++)
                if (dec_off == DIV * (1 + i) + DIV / 2) dec_byte[i] = TX;
            if (NB == 11 && dec_off == DIV * 9 + DIV / 2)
                chk("parity_bit", TX, ^dec_byte);
            if (dec_off == DIV * (NB - 1) + DIV / 2) begin
                chk("stop_bit", TX, 1);
                if (exp_q.size() == 0) chk("rx_queue_nonempty", exp_q.size(), 1);
                else chk("rx_byte", dec_byte, exp_q.pop_front());
                dec_active = 0;
            end
        end
        prev_tx = TX;
    endtask

    // One clock: model edge, then sample DUT on the falling edge.
    task automatic step();
        model_edge();
        @(negedge Clk);
        chk("tx", TX, m_tx);
        chk("count", Count, mq.size());
        chk("in_ready", InReady, ready_en && (mq.size() != DEPTH));
        chk("busy", Busy, in_frame || (mq.size() != 0));
        decode();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (Busy && n < 40 * FRAME) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, Busy, 0);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    // Single byte into an idle block: start 2 edges after the push,
    // Busy low once the full frame has been shifted.
    task automatic send_one(input logic [7:0] b, input string tag);
        int n;
        InValid = 1;
        InData  = b;
        step();
        InValid = 0;
        chk({tag, "_tx_at_push"}, TX, 1);
        step();
        n = 1;
        chk({tag, "_tx_start"}, TX, 0);
        while (Busy && n < 4 * FRAME) begin
            step();
            n++;
        end
        chk({tag, "_busy_cycles"}, n, FRAME + 1);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int n;

        // ---------- reset ----------
        Rst_n = 0; Clear = 0; InValid = 0; InData = '0;
        model_reset();
        step();
        step();
        chk("rst_tx", TX, 1);
        chk("rst_count", Count, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_ready", InReady, 0);
        Rst_n = 1;
        step();
        chk("ready_after_release", InReady, 1);
        repeat (3) step();

        // ---------- single byte ----------
        send_one(8'hA5, "a5");
        repeat (3) step();

        // ---------- burst to full, stalled 17th byte ----------
        InValid = 1; InData = 8'hEE; step(); InValid = 0;
        repeat (20) step();
        for (int i = 0; i < 16; i++) begin
            chk("burst_ready", InReady, 1);
            InValid = 1;
            InData  = i[7:0];
            step();
        end
        InValid = 0;
        chk("burst_count_full", Count, 16);
        chk("burst_ready_full", InReady, 0);
        InValid = 1; InData = 8'h10; n = 0;
        do begin
            step();
            n++;
        end while (!acc_last && n < 2 * FRAME);
        InValid = 0;
        chk("stall_count_after", Count, 16);
        chk("stall_ready_after", InReady, 0);
        wait_idle("burst");
        repeat (3) step();

        // ---------- Clear during 2nd of 4 frames ----------
        for (int i = 0; i < 4; i++) begin
            InValid = 1;
            InData  = 8'(8'h90 + i);
            step();
        end
        InValid = 0;
        repeat (125) step();
        Clear = 1; InValid = 1; InData = 8'hFF;
        step();
        Clear = 0; InValid = 0;
        chk("clr_tx", TX, 1);
        chk("clr_count", Count, 0);
        chk("clr_busy", Busy, 0);
        repeat (5) step();
        send_one(8'h3C, "clr_after");
        repeat (3) step();

        // ---------- reset mid-frame ----------
        InValid = 1; InData = 8'h81; step();
        InData = 8'h7E; step();
        InValid = 0;
        repeat (40) step();
        #2 Rst_n = 0;
        #1;
        chk("arst_tx", TX, 1);
        chk("arst_count", Count, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_ready", InReady, 0);
        model_reset();
        repeat (3) step();
        Rst_n = 1;
        step();
        chk("arst_ready_release", InReady, 1);
        repeat (2) step();
        send_one(8'h55, "arst_after");
        repeat (3) step();

        // ---------- parity-relevant bytes ----------
        send_one(8'h07, "b07");
        repeat (2) step();
        send_one(8'h03, "b03");
        repeat (2) step();

        // ---------- randomized traffic ----------
        sent = 0;
        for (int cyc = 0; cyc < 8000 && sent < 40; cyc++) begin
            if (!InValid && $urandom_range(0, 3) == 0) begin
                InValid = 1;
                InData  = 8'($urandom_range(0, 255));
            end
            Clear = ($urandom_range(0, 799) == 0);
            step();
            Clear = 0;
            if (acc_last) begin
                sent++;
                InValid = 0;
            end
        end
        InValid = 0;
        wait_idle("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
